perf_run_ctrl: RTL and testbench

//  Run controller for the core's performance counters: sequences a measurement run
//  (idle -> run -> drain -> done/timeout), counts cycles and retired instructions
//  (W_v), enforces a cycle watchdog, and exposes results through a req/ack readout port.

---
 rtl/perf_run_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_perf_run_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_run_ctrl.sv
// perf_run_ctrl: sequences one performance-measurement run.
// It counts cycles and retired instructions, runs a cycle watchdog, and
// returns results through a registered req/ack readout port.
//
// Readout handshake: rd_req is sampled on every rising edge in any state.
// One cycle later, rd_ack pulses high and rd_data carries the selected value
// as it stood at the request edge (before that edge's update). Back-to-back
// requests give back-to-back acks. Without a request, rd_ack is low and
// rd_data keeps its last value.
module perf_run_ctrl #(
    parameter int          CW      = 16,
    parameter int          IW      = 16,
    parameter int unsigned TIMEOUT = 300,
    parameter int          DRAIN   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          W_v,
    input  logic          isHalt,
    input  logic          rd_req,
    input  logic [1:0]    rd_sel,
    output logic          rd_ack,
    output logic [31:0]   rd_data,
    output logic [CW-1:0] cycle,
    output logic          running,
    output logic          done,
    output logic          timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int             DCW        = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);
    localparam logic [DCW-1:0] DRAIN_INIT = DCW'(DRAIN);
    localparam bit             WD_EN      = (TIMEOUT != 0);
    localparam logic [63:0]    WD_LAST    = 64'(TIMEOUT) - 64'd1;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cycle_q, cycle_d;
    logic [IW-1:0]  instrs_q, instrs_d;
    logic [CW-1:0]  snap_q, snap_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           tout_q, tout_d;
    logic           ovf_q, ovf_d;
    logic           rd_ack_q;
    logic [31:0]    rd_data_q;
    logic [31:0]    rd_mux;
    logic [4:0]     status;
    logic           wd_hit;
    logic           cycle_sat;
    logic           instrs_sat;

    // The watchdog fires on the last allowed RUN cycle. The cycle counter
    // still advances on that edge, so it reads TIMEOUT afterwards.
    assign wd_hit     = WD_EN && (64'(cycle_q) == WD_LAST);
    assign cycle_sat  = &cycle_q;
    assign instrs_sat = &instrs_q;

    // Status word: bits 1:0 state, bit 2 done, bit 3 timeout, bit 4 ovf.
    assign status = {ovf_q, tout_q, done, state_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In RUN, halt takes priority over the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (isHalt)      state_d = S_DRAIN;
                else if (wd_hit) state_d = S_DONE;
            end
            S_DRAIN: if (drain_q <= DCW'(1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        running = (state_q == S_RUN) || (state_q == S_DRAIN);
        done    = (state_q == S_DONE);
        timeout = tout_q;
        cycle   = cycle_q;
        rd_ack  = rd_ack_q;
        rd_data = rd_data_q;
    end

    // Counter, snapshot and flag updates. Counters saturate, and ovf latches.
    always_comb begin
        cycle_d  = cycle_q;
        instrs_d = instrs_q;
        snap_d   = snap_q;
        drain_d  = drain_q;
        tout_d   = tout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cycle_d  = '0;
                    instrs_d = '0;
                    snap_d   = '0;
                    tout_d   = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (cycle_sat) ovf_d = 1'b1;
                else           cycle_d = cycle_q + CW'(1);
                if (W_v) begin
                    if (instrs_sat) ovf_d = 1'b1;
                    else            instrs_d = instrs_q + IW'(1);
                end
                if (isHalt) begin
                    snap_d  = cycle_q;
                    drain_d = DRAIN_INIT;
                end else if (wd_hit) begin
                    snap_d = cycle_q;
                    tout_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (W_v) begin
                    if (instrs_sat) ovf_d = 1'b1;
                    else            instrs_d = instrs_q + IW'(1);
                end
                if (drain_q != '0) drain_d = drain_q - DCW'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q  <= '0;
            instrs_q <= '0;
            snap_q   <= '0;
            drain_q  <= '0;
            tout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            instrs_q <= instrs_d;
            snap_q   <= snap_d;
            drain_q  <= drain_d;
            tout_q   <= tout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Readout select, zero-extended to 32 bits
    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            2'd0:    rd_mux[CW-1:0] = cycle_q;
            2'd1:    rd_mux[IW-1:0] = instrs_q;
            2'd2:    rd_mux[4:0]    = status;
            default: rd_mux[CW-1:0] = snap_q;
        endcase
    end

    // Readout register: captures pre-update values at the request edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= rd_req;
            if (rd_req) rd_data_q <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_run_ctrl.sv
// Bench for perf_run_ctrl: two instances (a wide one with the watchdog and a
// 4-bit one without it) share the same stimulus and are compared each cycle
// against a phase-level model, plus directed literal checks.
module tb_perf_run_ctrl;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       w_v = 1'b0;
  logic       is_halt = 1'b0;
  logic       rd_req = 1'b0;
  logic [1:0] rd_sel = 2'd0;

  logic        ack0, run0, done0, tout0;
  logic [31:0] rdd0;
  logic [15:0] cyc0;
  logic        ack1, run1, done1, tout1;
  logic [31:0] rdd1;
  logic [3:0]  cyc1;

  perf_run_ctrl #(.CW(16), .IW(16), .TIMEOUT(300), .DRAIN(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .W_v(w_v), .isHalt(is_halt),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(ack0), .rd_data(rdd0),
    .cycle(cyc0), .running(run0), .done(done0), .timeout(tout0)
  );

  perf_run_ctrl #(.CW(4), .IW(4), .TIMEOUT(0), .DRAIN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .W_v(w_v), .isHalt(is_halt),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(ack1), .rd_data(rdd1),
    .cycle(cyc1), .running(run1), .done(done1), .timeout(tout1)
  );

  // scoreboard counters
  int n_chk = 0;
  int n_pass = 0;
  bit armed = 1'b0;

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, inst, act, exp, $time);
  endtask

  // behavioural model: phase 0 idle, 1 run, 2 drain, 3 done
  int cmax_a[2] = '{65535, 15};
  int imax_a[2] = '{65535, 15};
  int tmo_a[2]  = '{300, 0};
  int drn_a[2]  = '{2, 0};

  int m_ph[2], m_cyc[2], m_ins[2], m_snap[2], m_dleft[2];
  int m_tout[2], m_ovf[2], m_ack[2], m_data[2];

  function automatic int status_of(input int i);
    return m_ph[i] + ((m_ph[i] == 3) ? 4 : 0) + m_tout[i] * 8 + m_ovf[i] * 16;
  endfunction

  task automatic count_instr(input int i);
    if (m_ins[i] == imax_a[i]) m_ovf[i] = 1;
    else m_ins[i] = m_ins[i] + 1;
  endtask

  task automatic model_step(input int i);
    int old_c;
    if (rd_req) begin
      m_ack[i] = 1;
      case (rd_sel)
        2'd0: m_data[i] = m_cyc[i];
        2'd1: m_data[i] = m_ins[i];
        2'd2: m_data[i] = status_of(i);
        default: m_data[i] = m_snap[i];
      endcase
    end else begin
      m_ack[i] = 0;
    end
    case (m_ph[i])
      0, 3: begin
        if (start) begin
          m_cyc[i] = 0; m_ins[i] = 0; m_snap[i] = 0;
          m_tout[i] = 0; m_ovf[i] = 0; m_ph[i] = 1;
        end
      end
      1: begin
        old_c = m_cyc[i];
        if (m_cyc[i] == cmax_a[i]) m_ovf[i] = 1;
        else m_cyc[i] = m_cyc[i] + 1;
        if (w_v) count_instr(i);
        if (is_halt) begin
          m_snap[i] = old_c;
          m_ph[i] = 2;
          m_dleft[i] = (drn_a[i] == 0) ? 1 : drn_a[i];
        end else if (tmo_a[i] != 0 && old_c == tmo_a[i] - 1) begin
          m_snap[i] = old_c;
          m_tout[i] = 1;
          m_ph[i] = 3;
        end
      end
      default: begin
        if (w_v) count_instr(i);
        m_dleft[i] = m_dleft[i] - 1;
        if (m_dleft[i] == 0) m_ph[i] = 3;
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = 0; m_cyc[i] = 0; m_ins[i] = 0; m_snap[i] = 0; m_dleft[i] = 0;
        m_tout[i] = 0; m_ovf[i] = 0; m_ack[i] = 0; m_data[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // compare process: every negedge once armed
  always @(negedge clk) begin
    if (armed) begin
      check("cycle", 0, 32'(cyc0), 32'(m_cyc[0]));
      check("running", 0, 32'(run0), 32'((m_ph[0] == 1) || (m_ph[0] == 2)));
      check("done", 0, 32'(done0), 32'(m_ph[0] == 3));
      check("timeout", 0, 32'(tout0), 32'(m_tout[0]));
      check("rd_ack", 0, 32'(ack0), 32'(m_ack[0]));
      check("rd_data", 0, rdd0, 32'(m_data[0]));
      check("cycle", 1, 32'(cyc1), 32'(m_cyc[1]));
      check("running", 1, 32'(run1), 32'((m_ph[1] == 1) || (m_ph[1] == 2)));
      check("done", 1, 32'(done1), 32'(m_ph[1] == 3));
      check("timeout", 1, 32'(tout1), 32'(m_tout[1]));
      check("rd_ack", 1, 32'(ack1), 32'(m_ack[1]));
      check("rd_data", 1, rdd1, 32'(m_data[1]));
    end
  end

  // driver tasks
  logic [31:0] rd0, rd1;

  task automatic step(input logic s, input logic wv, input logic h);
    start = s; w_v = wv; is_halt = h; rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic read(input logic [1:0] sel);
    start = 1'b0; w_v = 1'b0; is_halt = 1'b0;
    rd_req = 1'b1; rd_sel = sel;
    @(posedge clk);
    #1;
    check("rd_ack_lit", 0, 32'(ack0), 32'd1);
    rd0 = rdd0;
    rd1 = rdd1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic run_halt(input int n, input logic [31:0] wv_mask, input logic [1:0] drain_wv);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= n; k++) step(1'b0, wv_mask[k-1], k == n);
    step(1'b0, drain_wv[0], 1'b0);
    check("drain1_running", 0, 32'(run0), 32'd1);
    check("drain1_done", 0, 32'(done0), 32'd0);
    step(1'b0, drain_wv[1], 1'b0);
    check("drain2_done", 0, 32'(done0), 32'd1);
  endtask

  int wv_cnt;

  initial begin
    #1 rst_n = 1'b0;
    armed = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle, no start
    repeat (10) step(1'b0, 1'b0, 1'b0);
    check("idle_cycle", 0, 32'(cyc0), 32'd0);
    read(2'd2);
    check("idle_status", 0, rd0, 32'h0);
    read(2'd1);
    check("idle_instrs", 0, rd0, 32'd0);

    // 2: 20-cycle run, 5 retires (one on the halt cycle), quiet drain
    run_halt(20, 32'h0008_8844, 2'b00);
    check("t2_cycle", 0, 32'(cyc0), 32'd20);
    check("t2_model_snap", 0, 32'(m_snap[0]), 32'd19);
    check("t2_model_ins", 0, 32'(m_ins[0]), 32'd5);
    read(2'd0); check("t2_rd_cycle", 0, rd0, 32'd20);
    read(2'd1); check("t2_rd_instrs", 0, rd0, 32'd5);
    read(2'd2); check("t2_rd_status", 0, rd0, 32'h7);
    read(2'd3); check("t2_rd_snap", 0, rd0, 32'd19);

    // 3: retires in both drain cycles
    run_halt(20, 32'h0008_8844, 2'b11);
    read(2'd1); check("t3_rd_instrs", 0, rd0, 32'd7);
    check("t3_cycle_frozen", 0, 32'(cyc0), 32'd20);

    // 4a: watchdog
    step(1'b1, 1'b0, 1'b0);
    wv_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      logic wv;
      wv = 1'($urandom_range(0, 1));
      wv_cnt += int'(wv);
      step(1'b0, wv, 1'b0);
    end
    check("t4_timeout", 0, 32'(tout0), 32'd1);
    check("t4_done", 0, 32'(done0), 32'd1);
    check("t4_cycle", 0, 32'(cyc0), 32'd300);
    read(2'd2); check("t4_rd_status", 0, rd0, 32'hF);
    read(2'd3); check("t4_rd_snap", 0, rd0, 32'd299);
    read(2'd1); check("t4_rd_instrs", 0, rd0, 32'(wv_cnt));

    // 4b: halt on the watchdog cycle wins
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 300; k++) step(1'b0, 1'b0, k == 300);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t4b_timeout", 0, 32'(tout0), 32'd0);
    check("t4b_cycle", 0, 32'(cyc0), 32'd300);
    read(2'd3); check("t4b_rd_snap", 0, rd0, 32'd299);
    read(2'd2); check("t4b_rd_status", 0, rd0, 32'h7);

    // 5: 4-bit instance saturates
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    check("t5_cycle_sat", 1, 32'(cyc1), 32'd15);
    read(2'd2); check("t5_status_ovf", 1, rd1, 32'h11);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    read(2'd2); check("t5_status_done", 1, rd1, 32'h17);
    step(1'b1, 1'b0, 1'b0);
    check("t5_cycle_clr", 1, 32'(cyc1), 32'd0);
    read(2'd2); check("t5_status_clr", 1, rd1, 32'h1);

    // 6a: back-to-back readout
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    w_v = 1'b1; rd_req = 1'b1; rd_sel = 2'd0;
    @(posedge clk); #1;
    check("b2b_ack0", 0, 32'(ack0), 32'd1);
    check("b2b_data0", 0, rdd0, 32'd4);
    @(negedge clk);
    w_v = 1'b0; rd_sel = 2'd1;
    @(posedge clk); #1;
    check("b2b_ack1", 0, 32'(ack0), 32'd1);
    check("b2b_data1", 0, rdd0, 32'd5);
    @(negedge clk);
    rd_req = 1'b0;
    @(posedge clk); #1;
    check("b2b_ack_low", 0, 32'(ack0), 32'd0);
    check("b2b_data_hold", 0, rdd0, 32'd5);

    // 6b: asynchronous reset during drain
    step(1'b0, 1'b0, 1'b1);
    start = 1'b0; w_v = 1'b0; is_halt = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_running", 0, 32'(run0), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_cycle", 0, 32'(cyc0), 32'd0);
    check("rst_running", 0, 32'(run0), 32'd0);
    check("rst_done", 0, 32'(done0), 32'd0);
    check("rst_timeout", 0, 32'(tout0), 32'd0);
    check("rst_ack", 0, 32'(ack0), 32'd0);
    check("rst_data", 0, rdd0, 32'd0);
    check("rst_cycle", 1, 32'(cyc1), 32'd0);
    check("rst_data", 1, rdd1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // random phase
    for (int n = 0; n < 1500; n++) begin
      start   = ($urandom_range(0, 19) == 0);
      w_v     = 1'($urandom_range(0, 1));
      is_halt = ($urandom_range(0, 29) == 0);
      rd_req  = 1'($urandom_range(0, 1));
      rd_sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0; w_v = 1'b0; is_halt = 1'b0; rd_req = 1'b0;
    @(negedge clk);

    // final report
    armed = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
